itlb_refill_ctrl: RTL and testbench

- 32-entry fully-associative ITLB data store with lookup and a miss/refill FSM.
- Drives the replacement-policy block from the opposite side of its interface:
  - produces valid vector, one-hot hit and hit-valid;
  - issues refill request and refill-valid;
  - consumes the one-hot refill victim.
- Sits between IFU translation request and the PTW. Replacement policy itself is instantiated alongside it in the MMS top.

---
 rtl/mms_pkg.sv | 37 +++
 rtl/itlb_tag_cam.sv | 42 ++++
 rtl/itlb_refill_ctrl.sv | 215 +++++++++++++++++++++
 tb/tb_itlb_refill_ctrl.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mms_pkg.sv
// -----------------------------------------------------------------------------
// mms_pkg
// Shared types and widths for the MMS instruction-side translation blocks.
//   VPN_W / PPN_W  : Sv39 virtual / physical page number widths
//   ENTRIES        : ITLB depth, taken from `TLB_ENTRY_SIZE (default 32)
//   itlb_entry_t   : one ITLB data-store entry (tag, translation, ASID when
//                    ITLB_ASID_EN is defined)
//   itlb_fsm_e     : miss/refill controller states
// Optional macro: ITLB_ASID_EN adds an ASID field to every entry.
// -----------------------------------------------------------------------------
`ifndef TLB_ENTRY_SIZE
`define TLB_ENTRY_SIZE 32
`endif

package mms_pkg;

    localparam int VPN_W   = 27;
    localparam int PPN_W   = 44;
    localparam int ASID_W  = 16;
    localparam int ENTRIES = `TLB_ENTRY_SIZE;

    typedef struct packed {
        logic [VPN_W-1:0]  vpn;
        logic [PPN_W-1:0]  ppn;
`ifdef ITLB_ASID_EN
        logic [ASID_W-1:0] asid;
`endif
    } itlb_entry_t;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        PTW,
        WAIT
    } itlb_fsm_e;

endpackage

// File: rtl/itlb_tag_cam.sv
// -----------------------------------------------------------------------------
// itlb_tag_cam
// Combinational fully-associative tag compare for the ITLB.
//   entries : stored entries (tag/ppn/asid)
//   valid   : per-entry valid bits
//   vpn     : lookup VPN
//   asid    : lookup ASID (only with ITLB_ASID_EN)
//   match   : per-entry match vector (one-hot or zero for a legal store)
//   ppn     : PPN of the matching entry, zero when nothing matches
// Optional macro: ITLB_ASID_EN makes a match also require an ASID match.
// -----------------------------------------------------------------------------
module itlb_tag_cam #(
    parameter int ENTRIES = mms_pkg::ENTRIES
) (
    input  mms_pkg::itlb_entry_t             entries [ENTRIES],
    input  logic [ENTRIES-1:0]               valid,
    input  logic [mms_pkg::VPN_W-1:0]        vpn,
`ifdef ITLB_ASID_EN
    input  logic [mms_pkg::ASID_W-1:0]       asid,
`endif
    output logic [ENTRIES-1:0]               match,
    output logic [mms_pkg::PPN_W-1:0]        ppn
);

    // NOTE: every output gets a default before the loop so no latch is inferred.
    always_comb begin
        match = '0;
        ppn   = '0;
        for (int i = 0; i < ENTRIES; i++) begin
`ifdef ITLB_ASID_EN
            match[i] = valid[i] && (entries[i].vpn == vpn) && (entries[i].asid == asid);
`else
            match[i] = valid[i] && (entries[i].vpn == vpn);
`endif
            // OR-mux is exact because the match vector is at most one-hot.
            if (match[i]) begin
                ppn = ppn | entries[i].ppn;
            end
        end
    end

endmodule

// File: rtl/itlb_refill_ctrl.sv
// -----------------------------------------------------------------------------
// itlb_refill_ctrl
// 32-entry fully-associative ITLB data store with combinational lookup and a
// miss/refill FSM (IDLE -> REQ -> PTW -> WAIT -> IDLE) towards the PTW. It
// feeds the replacement-policy block (valid vector, one-hot hit, refill
// request/valid) and writes the victim that block returns, verbatim.
// Ports:
//   clk_i, rstn_i                 clock, async active-low reset
//   lkp_*                         IFU lookup request / hit / miss / ppn / pf
//   flush_i                       sfence.vma
//   entry_valid_o, rd_hit_o,
//   hit_vld_o, refill_rq_o,
//   refill_onehot_i, refill_vld_o replacement-policy interface
//   ptw_req_*, ptw_resp_*         page-table walker request / response
// Optional macro: ITLB_ASID_EN adds lkp_asid_i, flush_asid_i, flush_all_i;
// entries then carry an ASID and flush_i only hits matching ASIDs unless
// flush_all_i is set.
// -----------------------------------------------------------------------------
module itlb_refill_ctrl #(
    parameter int ENTRIES = `TLB_ENTRY_SIZE,
    parameter int VPN_W   = mms_pkg::VPN_W,
    parameter int PPN_W   = mms_pkg::PPN_W
) (
    input  logic               clk_i,
    input  logic               rstn_i,
    input  logic               lkp_vld_i,
    input  logic [VPN_W-1:0]   lkp_vpn_i,
`ifdef ITLB_ASID_EN
    input  logic [15:0]        lkp_asid_i,
    input  logic [15:0]        flush_asid_i,
    input  logic               flush_all_i,
`endif
    output logic               lkp_rdy_o,
    output logic               lkp_hit_o,
    output logic               lkp_miss_o,
    output logic [PPN_W-1:0]   lkp_ppn_o,
    output logic               lkp_pf_o,
    input  logic               flush_i,
    output logic [ENTRIES-1:0] entry_valid_o,
    output logic [ENTRIES-1:0] rd_hit_o,
    output logic               hit_vld_o,
    output logic               refill_rq_o,
    input  logic [ENTRIES-1:0] refill_onehot_i,
    output logic               refill_vld_o,
    output logic               ptw_req_vld_o,
    output logic [VPN_W-1:0]   ptw_req_vpn_o,
    input  logic               ptw_req_rdy_i,
    input  logic               ptw_resp_vld_i,
    input  logic [PPN_W-1:0]   ptw_resp_ppn_i,
    input  logic               ptw_resp_pf_i
);

    import mms_pkg::*;

    itlb_fsm_e          state_q, state_d;
    logic [ENTRIES-1:0] valid_q;
    itlb_entry_t        entries_q [ENTRIES];
    itlb_entry_t        new_entry;
    logic [VPN_W-1:0]   miss_vpn_q;
    logic               kill_q;
    logic               drain_q;
    logic [ENTRIES-1:0] match;
    logic [ENTRIES-1:0] flush_mask;
    logic [PPN_W-1:0]   hit_ppn;
    logic               lkp_ok;
`ifdef ITLB_ASID_EN
    logic [ASID_W-1:0]  miss_asid_q;
`endif

    itlb_tag_cam #(.ENTRIES(ENTRIES)) u_cam (
        .entries (entries_q),
        .valid   (valid_q),
        .vpn     (lkp_vpn_i),
`ifdef ITLB_ASID_EN
        .asid    (lkp_asid_i),
`endif
        .match   (match),
        .ppn     (hit_ppn)
    );

    // ---------------- lookup ----------------
    assign lkp_rdy_o     = (state_q == IDLE);
    assign lkp_ok        = lkp_vld_i && lkp_rdy_o && !flush_i;
    assign lkp_hit_o     = lkp_ok && (|match);
    assign lkp_miss_o    = lkp_ok && !(|match);
    assign lkp_ppn_o     = hit_ppn;
    assign rd_hit_o      = lkp_hit_o ? match : '0;
    assign hit_vld_o     = lkp_hit_o;
    assign entry_valid_o = valid_q;
    assign ptw_req_vpn_o = miss_vpn_q;

    // ---------------- FSM ----------------
    always_comb begin
        state_d       = state_q;
        refill_rq_o   = 1'b0;
        ptw_req_vld_o = 1'b0;
        refill_vld_o  = 1'b0;
        lkp_pf_o      = 1'b0;
        case (state_q)
            IDLE: if (lkp_miss_o) state_d = REQ;
            REQ: begin
                refill_rq_o = 1'b1;
                state_d     = PTW;
            end
            PTW: begin
                ptw_req_vld_o = 1'b1;
                if (ptw_req_rdy_i) state_d = WAIT;
            end
            WAIT: begin
                if (ptw_resp_vld_i) begin
                    state_d = IDLE;
                    // A flush seen during the walk (or right now) makes the
                    // translation stale: drop it without writing or faulting.
                    if (!(kill_q || flush_i)) begin
                        refill_vld_o = !ptw_resp_pf_i;
                        lkp_pf_o     = ptw_resp_pf_i;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state is updated with non-blocking assignments only.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Sticky kill: any flush while a miss is outstanding; cleared back in IDLE.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            kill_q <= 1'b0;
        end else if (state_q == IDLE) begin
            kill_q <= 1'b0;
        end else if (flush_i) begin
            kill_q <= 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            miss_vpn_q  <= '0;
`ifdef ITLB_ASID_EN
            miss_asid_q <= '0;
`endif
        end else if (lkp_miss_o) begin
            miss_vpn_q  <= lkp_vpn_i;
`ifdef ITLB_ASID_EN
            miss_asid_q <= lkp_asid_i;
`endif
        end
    end

    // ---------------- data store ----------------
    always_comb begin
        flush_mask = '1;
`ifdef ITLB_ASID_EN
        if (!flush_all_i) begin
            for (int i = 0; i < ENTRIES; i++) begin
                flush_mask[i] = (entries_q[i].asid == flush_asid_i);
            end
        end
`endif
    end

    always_comb begin
        new_entry      = '0;
        new_entry.vpn  = miss_vpn_q;
        new_entry.ppn  = ptw_resp_ppn_i;
`ifdef ITLB_ASID_EN
        new_entry.asid = miss_asid_q;
`endif
    end

    // Flush wins over a same-cycle write.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            valid_q <= '0;
        end else if (flush_i) begin
            valid_q <= valid_q & ~flush_mask;
        end else if (refill_vld_o) begin
            valid_q <= valid_q | refill_onehot_i;
        end
    end

    // NOTE: tag/ppn storage is not reset; valid_q alone qualifies its contents.
    always_ff @(posedge clk_i) begin
        for (int i = 0; i < ENTRIES; i++) begin
            if (refill_vld_o && refill_onehot_i[i]) begin
                entries_q[i] <= new_entry;
            end
        end
    end

    // After reset a walk started before reset may still answer while we sit
    // in IDLE; that single stale response is expected and ignored.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            drain_q <= 1'b1;
        end else if (lkp_miss_o) begin
            drain_q <= 1'b0;
        end
    end

    a_hit_onehot: assert property (@(posedge clk_i) disable iff (!rstn_i)
        $onehot0(match));

    a_resp_in_wait: assert property (@(posedge clk_i) disable iff (!rstn_i)
        ptw_resp_vld_i |-> (state_q == WAIT) || (state_q == IDLE && drain_q));

endmodule

// File: tb/tb_itlb_refill_ctrl.sv
// -----------------------------------------------------------------------------
// tb_itlb_refill_ctrl
// Self-checking bench for itlb_refill_ctrl. The bench plays IFU, PTW and the
// replacement block (lowest invalid entry, else a random victim) and keeps a
// behavioural model of the TLB contents as plain arrays.
// -----------------------------------------------------------------------------
module tb_itlb_refill_ctrl;
    import mms_pkg::*;

    localparam int N = ENTRIES;

    logic             clk_i = 1'b0;
    logic             rstn_i = 1'b0;
    logic             lkp_vld_i = 1'b0;
    logic [VPN_W-1:0] lkp_vpn_i = '0;
    logic             lkp_rdy_o, lkp_hit_o, lkp_miss_o, lkp_pf_o;
    logic [PPN_W-1:0] lkp_ppn_o;
    logic             flush_i = 1'b0;
    logic [N-1:0]     entry_valid_o, rd_hit_o;
    logic             hit_vld_o, refill_rq_o, refill_vld_o, ptw_req_vld_o;
    logic [N-1:0]     refill_onehot_i = '0;
    logic [VPN_W-1:0] ptw_req_vpn_o;
    logic             ptw_req_rdy_i = 1'b0;
    logic             ptw_resp_vld_i = 1'b0;
    logic [PPN_W-1:0] ptw_resp_ppn_i = '0;
    logic             ptw_resp_pf_i = 1'b0;

    always #5 clk_i = ~clk_i;

    itlb_refill_ctrl dut (
        .clk_i           (clk_i),
        .rstn_i          (rstn_i),
        .lkp_vld_i       (lkp_vld_i),
        .lkp_vpn_i       (lkp_vpn_i),
`ifdef ITLB_ASID_EN
        .lkp_asid_i      (16'h0),
        .flush_asid_i    (16'h0),
        .flush_all_i     (1'b1),
`endif
        .lkp_rdy_o       (lkp_rdy_o),
        .lkp_hit_o       (lkp_hit_o),
        .lkp_miss_o      (lkp_miss_o),
        .lkp_ppn_o       (lkp_ppn_o),
        .lkp_pf_o        (lkp_pf_o),
        .flush_i         (flush_i),
        .entry_valid_o   (entry_valid_o),
        .rd_hit_o        (rd_hit_o),
        .hit_vld_o       (hit_vld_o),
        .refill_rq_o     (refill_rq_o),
        .refill_onehot_i (refill_onehot_i),
        .refill_vld_o    (refill_vld_o),
        .ptw_req_vld_o   (ptw_req_vld_o),
        .ptw_req_vpn_o   (ptw_req_vpn_o),
        .ptw_req_rdy_i   (ptw_req_rdy_i),
        .ptw_resp_vld_i  (ptw_resp_vld_i),
        .ptw_resp_ppn_i  (ptw_resp_ppn_i),
        .ptw_resp_pf_i   (ptw_resp_pf_i)
    );

    int checks = 0;
    int errors = 0;
    int hs_cnt = 0;

    always @(posedge clk_i) if (ptw_req_vld_o && ptw_req_rdy_i) hs_cnt++;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    bit               m_valid [N];
    logic [VPN_W-1:0] m_vpn   [N];
    logic [PPN_W-1:0] m_ppn   [N];

    function automatic int m_find(input logic [VPN_W-1:0] vpn);
        for (int i = 0; i < N; i++) if (m_valid[i] && m_vpn[i] == vpn) return i;
        return -1;
    endfunction

    function automatic logic [N-1:0] m_mask();
        logic [N-1:0] m = '0;
        for (int i = 0; i < N; i++) m[i] = m_valid[i];
        return m;
    endfunction

    function automatic int m_victim();
        for (int i = 0; i < N; i++) if (!m_valid[i]) return i;
        return int'($urandom_range(N - 1));
    endfunction

    task automatic m_clear();
        for (int i = 0; i < N; i++) m_valid[i] = 1'b0;
    endtask

    // One IFU access, entered and left just after a falling edge.
    // fmode: 0 none, 1 flush in PTW, 2 flush in WAIT, 3 flush on response
    // cycle, 4 reset in WAIT followed by a stale response.
    task automatic access(input logic [VPN_W-1:0] vpn, input logic [PPN_W-1:0] ppn,
                          input bit pf, input int delay, input int fmode, input int force_victim);
        int idx, victim, hs0;
        bit killed;
        logic [N-1:0] oh;
        idx = m_find(vpn);
        lkp_vld_i = 1'b1;
        lkp_vpn_i = vpn;
        #1;
        check("lkp_rdy_idle", lkp_rdy_o, 1);
        check("lkp_hit", lkp_hit_o, idx >= 0);
        check("lkp_miss", lkp_miss_o, idx < 0);
        if (idx >= 0) begin
            oh = '0;
            oh[idx] = 1'b1;
            check("lkp_ppn", lkp_ppn_o, m_ppn[idx]);
            check("rd_hit", rd_hit_o, oh);
            check("hit_vld", hit_vld_o, 1);
        end
        @(negedge clk_i);
        lkp_vld_i = 1'b0;
        if (idx >= 0) return;

        hs0    = hs_cnt;
        victim = (force_victim >= 0) ? force_victim : m_victim();
        killed = 1'b0;
        #1;
        check("refill_rq_pulse", refill_rq_o, 1);
        check("lkp_rdy_busy", lkp_rdy_o, 0);
        @(negedge clk_i);
        oh = '0;
        oh[victim] = 1'b1;
        refill_onehot_i = oh;
        if (fmode == 1) begin
            flush_i = 1'b1;
            killed  = 1'b1;
            m_clear();
        end
        for (int c = 0; c < delay; c++) begin
            #1;
            check("ptw_vld_hold", ptw_req_vld_o, 1);
            check("ptw_vpn_hold", ptw_req_vpn_o, vpn);
            check("refill_rq_once", refill_rq_o, 0);
            @(negedge clk_i);
            flush_i = 1'b0;
        end
        #1;
        check("ptw_vld", ptw_req_vld_o, 1);
        check("ptw_vpn", ptw_req_vpn_o, vpn);
        ptw_req_rdy_i = 1'b1;
        @(negedge clk_i);
        ptw_req_rdy_i = 1'b0;
        flush_i = 1'b0;
        #1;
        check("ptw_vld_drop", ptw_req_vld_o, 0);
        check("ptw_handshakes", hs_cnt - hs0, 1);

        if (fmode == 4) begin
            rstn_i = 1'b0;
            #1;
            m_clear();
            check("rst_rdy", lkp_rdy_o, 1);
            check("rst_outs", {refill_rq_o, refill_vld_o, ptw_req_vld_o, lkp_pf_o, hit_vld_o}, 0);
            check("rst_valid", entry_valid_o, 0);
            @(negedge clk_i);
            rstn_i = 1'b1;
            ptw_resp_vld_i = 1'b1;
            ptw_resp_ppn_i = ppn;
            ptw_resp_pf_i  = 1'b0;
            #1;
            check("stale_refill_vld", refill_vld_o, 0);
            @(negedge clk_i);
            ptw_resp_vld_i = 1'b0;
            #1;
            check("stale_valid", entry_valid_o, 0);
            check("stale_rdy", lkp_rdy_o, 1);
            return;
        end
        if (fmode == 2) begin
            flush_i = 1'b1;
            killed  = 1'b1;
            m_clear();
            @(negedge clk_i);
            flush_i = 1'b0;
        end
        ptw_resp_vld_i = 1'b1;
        ptw_resp_ppn_i = ppn;
        ptw_resp_pf_i  = pf;
        if (fmode == 3) begin
            flush_i = 1'b1;
            killed  = 1'b1;
            m_clear();
        end
        #1;
        check("refill_vld", refill_vld_o, !killed && !pf);
        check("lkp_pf", lkp_pf_o, !killed && pf);
        @(negedge clk_i);
        ptw_resp_vld_i = 1'b0;
        flush_i = 1'b0;
        if (!killed && !pf) begin
            m_valid[victim] = 1'b1;
            m_vpn[victim]   = vpn;
            m_ppn[victim]   = ppn;
        end
        #1;
        check("back_idle", lkp_rdy_o, 1);
        check("entry_valid", entry_valid_o, m_mask());
    endtask

    typedef struct {
        logic [VPN_W-1:0] vpn;
        logic [PPN_W-1:0] ppn;
        bit               pf;
        int               delay;
        int               fmode;
        logic [N-1:0]     exp_valid;
    } vec_t;

    vec_t vecs [11];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vecs[0]  = '{27'h1234, 44'hABC,  1'b0, 0, 0, 32'h1};  // cold miss
        vecs[1]  = '{27'h1234, 44'h0,    1'b0, 0, 0, 32'h1};  // replay hits
        vecs[2]  = '{27'h55,   44'h777,  1'b1, 0, 0, 32'h1};  // page fault
        vecs[3]  = '{27'h2000, 44'h2222, 1'b0, 5, 0, 32'h3};  // PTW stall 5
        vecs[4]  = '{27'h2000, 44'h0,    1'b0, 0, 0, 32'h3};
        vecs[5]  = '{27'h3000, 44'h3333, 1'b0, 1, 2, 32'h0};  // flush in WAIT
        vecs[6]  = '{27'h1234, 44'hABD,  1'b0, 0, 0, 32'h1};
        vecs[7]  = '{27'h4000, 44'h4444, 1'b0, 0, 3, 32'h0};  // flush on resp
        vecs[8]  = '{27'h5000, 44'h5555, 1'b0, 2, 1, 32'h0};  // flush in PTW
        vecs[9]  = '{27'h6000, 44'h6666, 1'b0, 0, 0, 32'h1};
        vecs[10] = '{27'h7000, 44'h7777, 1'b0, 1, 4, 32'h0};  // reset in WAIT

        m_clear();
        #1;
        check("reset_rdy", lkp_rdy_o, 1);
        check("reset_outs", {refill_rq_o, refill_vld_o, ptw_req_vld_o, lkp_pf_o, hit_vld_o}, 0);
        check("reset_valid", entry_valid_o, 0);
        @(negedge clk_i);
        @(negedge clk_i);
        rstn_i = 1'b1;
        @(negedge clk_i);

        for (int v = 0; v < 11; v++) begin
            access(vecs[v].vpn, vecs[v].ppn, vecs[v].pf, vecs[v].delay, vecs[v].fmode, -1);
            check($sformatf("tbl_valid_%0d", v), entry_valid_o, vecs[v].exp_valid);
        end

        // Fill all entries in index order, then replay every one.
        flush_i = 1'b1;
        @(negedge clk_i);
        flush_i = 1'b0;
        m_clear();
        for (int i = 0; i < N; i++) access(27'h100 + 27'(i), 44'h9000 + 44'(i), 1'b0, 0, 0, -1);
        check("fill_all", entry_valid_o, {N{1'b1}});
        for (int i = 0; i < N; i++) access(27'h100 + 27'(i), 44'h0, 1'b0, 0, 0, -1);

        // 33rd miss with a chosen victim; the evicted VPN must now miss.
        begin
            int v33;
            v33 = int'($urandom_range(N - 1));
            access(27'h999, 44'h999, 1'b0, 0, 0, v33);
            access(27'h999, 44'h0, 1'b0, 0, 0, -1);
            access(27'h100 + 27'(v33), 44'hBEEF, 1'b0, 0, 0, -1);
        end

        // Randomized traffic over a VPN pool wider than the TLB.
        for (int it = 0; it < 250; it++) begin
            if ($urandom_range(19) == 0) begin
                flush_i   = 1'b1;
                lkp_vld_i = 1'b1;
                lkp_vpn_i = 27'h100 + 27'($urandom_range(47));
                #1;
                check("flush_blocks_lkp", {lkp_hit_o, lkp_miss_o}, 0);
                @(negedge clk_i);
                flush_i   = 1'b0;
                lkp_vld_i = 1'b0;
                m_clear();
                #1;
                check("flush_valid", entry_valid_o, 0);
            end
            access(27'h100 + 27'($urandom_range(47)),
                   {12'($urandom), $urandom},
                   ($urandom_range(7) == 0),
                   int'($urandom_range(3)),
                   ($urandom_range(9) == 0) ? int'($urandom_range(3, 1)) : 0,
                   -1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
